imply_dispatch: RTL
===================

Name: imply_dispatch

Overview:
- Consumer end of the imply stack in the DPLL core.
- Pops implied literals {val, variable} and checks each against an internal per-variable assignment table.
- New assignments are committed and forwarded to the clause evaluator over a valid/ready handshake.
- Duplicates are dropped; a contradicting literal raises conflict and flushes the remaining stack.

Parameters:
- NUM_VARIABLE, 128, number of SAT variables; sizes the assignment table.
- VAR_W, 9, width of a variable index; must satisfy 2^VAR_W >= NUM_VARIABLE.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clock.
- start  in  1  one-cycle pulse; begin draining the stack. Ignored unless state is IDLE.
- stk_en  out  1  imply stack access enable.
- stk_rw  out  1  stack direction; constant 0 (pop).
- stk_type  in  1  entry type from stack; 1 = implied. Must be 1, otherwise the entry is treated as implied anyway.
- stk_val  in  1  popped literal polarity.
- stk_var  in  VAR_W  popped variable index.
- stk_empty  in  1  stack empty flag.
- out_valid  out  1  committed assignment available.
- out_ready  in  1  evaluator accepts the assignment.
- out_val  out  1  committed polarity.
- out_var  out  VAR_W  committed variable index.
- unassign_en  in  1  backtrack: clear one table entry.
- unassign_var  in  VAR_W  variable to clear.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; stack drained without conflict.
- conflict  out  1  sticky until the next start or reset.
- conflict_var  out  VAR_W  variable that caused the conflict.

Behaviour:
- Reset:
  - State IDLE; all table entries UNASSIGNED (2-bit code: 00 = U, 10 = F, 11 = T).
  - All outputs 0: stk_en, out_valid, out_val, out_var, busy, done, conflict, conflict_var.
  - Reset mid-operation aborts immediately; no stack access is issued in the reset cycle.
- FSM states: IDLE, POP, WAIT, LOOKUP, EMIT, FLUSH, FLUSH_WAIT.
- IDLE:
  - On start: clear conflict and go to POP.
- POP:
  - If stk_empty=1: pulse done and go to IDLE.
  - Otherwise drive stk_en=1, stk_rw=0 for exactly one cycle, then go to WAIT.
- WAIT:
  - Stack registers its data; go to LOOKUP.
- LOOKUP (data valid this cycle):
  - Table U: write {1, stk_val}, latch out_var/out_val, go to EMIT.
  - Table equals stk_val: duplicate, drop, go to POP.
  - Table is the opposite value: set conflict=1, conflict_var=stk_var, go to FLUSH.
- EMIT:
  - Hold out_valid=1 with out_var/out_val stable until out_ready=1.
  - On the handshake cycle, deassert out_valid next cycle and go to POP.
  - out_valid never drops without a handshake, except on reset.
- FLUSH:
  - If stk_empty=1: go to IDLE; done is not pulsed.
  - Otherwise pop (stk_en=1), go to FLUSH_WAIT, then return to FLUSH.
  - Flushed entries are discarded without a table lookup.
- Throughput: one pop per 3 cycles on the drop path; 4 or more cycles on the commit path.
- unassign_en:
  - Accepted in any state; writes U to entry unassign_var.
  - If it coincides with a LOOKUP table write to the same variable, the LOOKUP write wins.
  - LOOKUP reads the pre-write table (no bypass of an unassign in the same cycle).
  - unassign_var >= NUM_VARIABLE is ignored.
- stk_var >= NUM_VARIABLE in LOOKUP: treated as a duplicate (dropped); no table write.
- start while busy is ignored.

Optional Feature:
- Macro: IMPLY_DISPATCH_STATS_EN.
- Defined:
  - Adds outputs stat_commit, stat_dup, stat_flush, each 16 bits.
  - Counts per start session; cleared on start and on reset; saturate at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (sat_pkg):
  - VAR_W.
  - Assignment enum {ASSIGN_U=2'b00, ASSIGN_F=2'b10, ASSIGN_T=2'b11}.
  - Stack entry struct {type, val, var}.
  - Dispatch state enum.
- Sub-module assign_table:
  - NUM_VARIABLE x 2-bit register file.
  - One combinational read port, one write port, one clear port; write has priority over clear.

Test Plan:
- Stack empty, pulse start -> no stk_en pulse; done pulses 1 cycle later; conflict=0.
- Stack {1,5},{0,7}, out_ready=1 -> two handshakes: var 7 val 0, then var 5 val 1; table[7]=F, table[5]=T; done pulses.
- Stack {1,5},{1,5} -> one handshake only (duplicate dropped); done pulses.
- Stack {1,3},{0,3},{1,9},{1,10} (top {1,3}) -> var 3 emitted, then conflict=1, conflict_var=3; both remaining entries popped; stk_empty reached; no done; var 9 stays U.
- out_ready held 0 for 5 cycles in EMIT -> out_valid and data stable for all 5 cycles; no further stk_en until the handshake.
- Reset asserted during FLUSH -> next cycle IDLE, conflict=0, table all U, stk_en=0; unassign_en on var 5 after commit -> table[5]=U, re-push {1,5} re-commits.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types for the DPLL imply path: variable width, assignment codes,
// stack entry layout, dispatch FSM states and a saturating counter helper.
package sat_pkg;

    localparam int VAR_W = 9;

    typedef enum logic [1:0] {
        ASSIGN_U = 2'b00,
        ASSIGN_F = 2'b10,
        ASSIGN_T = 2'b11
    } assign_e;

    typedef struct packed {
        logic             typ;
        logic             val;
        logic [VAR_W-1:0] var_idx;
    } stk_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_POP        = 3'd1,
        ST_WAIT       = 3'd2,
        ST_LOOKUP     = 3'd3,
        ST_EMIT       = 3'd4,
        ST_FLUSH      = 3'd5,
        ST_FLUSH_WAIT = 3'd6
    } dispatch_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/assign_table.sv
// Per-variable assignment register file: async read, one write, one clear.
// Write lands next edge; write beats clear on the same entry; out-of-range indices ignored.
// No backpressure.
module assign_table
    import sat_pkg::*;
#(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [VAR_W-1:0] rd_var,
    output assign_e          rd_data,
    input  logic             wr_en,
    input  logic [VAR_W-1:0] wr_var,
    input  assign_e          wr_data,
    input  logic             clr_en,
    input  logic [VAR_W-1:0] clr_var
);

    localparam int              IDX_W = $clog2(NUM_VARIABLE);
    localparam logic [VAR_W:0]  NUM_V = (VAR_W+1)'(NUM_VARIABLE);

    assign_e tbl_q [NUM_VARIABLE];

    always_comb begin
        rd_data = ASSIGN_U;
        if ({1'b0, rd_var} < NUM_V) begin
            rd_data = tbl_q[rd_var[IDX_W-1:0]];
        end
    end

    // Later non-blocking write wins, giving the write port priority over clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_VARIABLE; i++) begin
                tbl_q[i] <= ASSIGN_U;
            end
        end else begin
            if (clr_en && ({1'b0, clr_var} < NUM_V)) begin
                tbl_q[clr_var[IDX_W-1:0]] <= ASSIGN_U;
            end
            if (wr_en && ({1'b0, wr_var} < NUM_V)) begin
                tbl_q[wr_var[IDX_W-1:0]] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/imply_dispatch.sv
// Drains the imply stack, commits new literals, drops duplicates, flushes on conflict (stats: IMPLY_DISPATCH_STATS_EN).
// Pop-to-lookup 3 cycles; commit path adds at least one EMIT cycle.
// Holds out_valid/data until out_ready; no further pops while waiting.
module imply_dispatch
    import sat_pkg::*;
#(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             stk_en,
    output logic             stk_rw,
    input  logic             stk_type,
    input  logic             stk_val,
    input  logic [VAR_W-1:0] stk_var,
    input  logic             stk_empty,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_val,
    output logic [VAR_W-1:0] out_var,
    input  logic             unassign_en,
    input  logic [VAR_W-1:0] unassign_var,
    output logic             busy,
    output logic             done,
    output logic             conflict,
    output logic [VAR_W-1:0] conflict_var
`ifdef IMPLY_DISPATCH_STATS_EN
    ,
    output logic [15:0]      stat_commit,
    output logic [15:0]      stat_dup,
    output logic [15:0]      stat_flush
`endif
);

    localparam logic [VAR_W:0] NUM_V = (VAR_W+1)'(NUM_VARIABLE);

    dispatch_state_e state_q, state_d;
    assign_e         cur_asg;
    assign_e         lit_asg;
    logic            var_ok;
    logic            commit;
    logic            dup;
    logic            clash;
    logic            flush_pop;
    logic            session_start;
    logic            unused_stk_type;

    // Every popped entry is handled as implied regardless of its type bit.
    assign unused_stk_type = stk_type;

    assign lit_asg       = stk_val ? ASSIGN_T : ASSIGN_F;
    assign var_ok        = ({1'b0, stk_var} < NUM_V);
    assign session_start = (state_q == ST_IDLE) && start;

    assign_table #(
        .NUM_VARIABLE (NUM_VARIABLE),
        .VAR_W        (VAR_W)
    ) u_table (
        .clock   (clock),
        .reset   (reset),
        .rd_var  (stk_var),
        .rd_data (cur_asg),
        .wr_en   (commit),
        .wr_var  (stk_var),
        .wr_data (lit_asg),
        .clr_en  (unassign_en),
        .clr_var (unassign_var)
    );

    always_comb begin
        state_d   = state_q;
        stk_en    = 1'b0;
        done      = 1'b0;
        commit    = 1'b0;
        dup       = 1'b0;
        clash     = 1'b0;
        flush_pop = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_POP;
            ST_POP: begin
                if (stk_empty) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stk_en  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (!var_ok || cur_asg == lit_asg) begin
                    dup     = 1'b1;
                    state_d = ST_POP;
                end else if (cur_asg == ASSIGN_U) begin
                    commit  = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    clash   = 1'b1;
                    state_d = ST_FLUSH;
                end
            end
            ST_EMIT: if (out_ready) state_d = ST_POP;
            ST_FLUSH: begin
                if (stk_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    stk_en    = 1'b1;
                    flush_pop = 1'b1;
                    state_d   = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: state_d = ST_FLUSH;
            default: state_d = ST_IDLE;
        endcase
        // The reset cycle must not touch the stack or signal completion.
        if (reset) begin
            stk_en = 1'b0;
            done   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            out_val      <= 1'b0;
            out_var      <= '0;
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else begin
            state_q <= state_d;
            if (session_start) conflict <= 1'b0;
            if (clash) begin
                conflict     <= 1'b1;
                conflict_var <= stk_var;
            end
            if (commit) begin
                out_val <= stk_val;
                out_var <= stk_var;
            end
        end
    end

    assign stk_rw    = 1'b0;
    assign out_valid = !reset && (state_q == ST_EMIT);
    assign busy      = !reset && (state_q != ST_IDLE);

`ifdef IMPLY_DISPATCH_STATS_EN
    always_ff @(posedge clock) begin
        if (reset || session_start) begin
            stat_commit <= '0;
            stat_dup    <= '0;
            stat_flush  <= '0;
        end else begin
            if (commit)    stat_commit <= sat_inc16(stat_commit);
            if (dup)       stat_dup    <= sat_inc16(stat_dup);
            if (flush_pop) stat_flush  <= sat_inc16(stat_flush);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = dup ^ flush_pop;
`endif

endmodule
